ula_multiciclo: RTL and testbench
=================================

ULA_MULTICICLO -- requirements
Module: ula_multiciclo

Interface
REQ-001 Parameter WIDTH, 32, operand/result width; SHALL be a power of two, 8..64.
REQ-002 Parameter SEL_W, 4, opcode width.
REQ-003 Clock_in  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 Signal_reset  in  1  asynchronous, active-high reset.
REQ-005 Start  in  1  request; sampled only while Busy=0.
REQ-006 Sel  in  SEL_W  opcode.
REQ-007 Data_1, Data_2  in  WIDTH  operands.
REQ-008 Out  out  WIDTH  registered result.
REQ-009 Overflow, Zero  out  1  registered flags for Out.
REQ-010 Busy  out  1  high while a multi-cycle op runs.
REQ-011 Done  out  1  one-cycle pulse when Out/flags update.

Function
REQ-012 Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT (signed, Out=0/1), 7 SLL, 8 SRL, 9 SRA, 10 MUL; 11-15 SHALL give Out=0, Overflow=0, Done pulse.
REQ-013 Shift amount SHALL be Data_2[$clog2(WIDTH)-1:0]; upper bits ignored.
REQ-014 Overflow: ADD/SUB two's-complement signed overflow; MUL unsigned, set when upper WIDTH bits of the 2*WIDTH product are nonzero; all other ops 0.
REQ-015 MUL Out SHALL be low WIDTH bits of unsigned product.
REQ-016 Zero SHALL equal (Out==0), updated in the same edge as Out.
REQ-017 FSM states IDLE, MULT. IDLE+Start+Sel!=MUL -> Out/flags/Done=1 at the next edge, stay IDLE (latency 1).
REQ-018 IDLE+Start+Sel==MUL -> latch operands, enter MULT, Busy=1; one shift-add iteration per cycle; after WIDTH iterations write Out/flags, Done=1, Busy=0, return IDLE (latency WIDTH).
REQ-019 Start, Sel, Data_* SHALL be ignored while Busy=1; operand changes during MULT SHALL not affect the result.
REQ-020 Done SHALL be high exactly one cycle per accepted Start; Start in the Done cycle SHALL be accepted (back-to-back).
REQ-021 Out and flags SHALL hold their value between Done pulses.
REQ-022 Iteration counter SHALL be $clog2(WIDTH)+1 bits; no wrap before termination.

Reset
REQ-023 Signal_reset=1 SHALL immediately force Out=0, Overflow=0, Zero=1, Busy=0, Done=0, state IDLE, counter 0.
REQ-024 Reset during MULT SHALL abort the op; no Done pulse SHALL follow release.
REQ-025 Start sampled in the first edge after reset release SHALL be accepted.

Structure
REQ-026 Package ula_pkg SHALL hold opcode constants (SEL_W wide) and FSM state encoding.
REQ-027 Sub-module ula_mult_iter SHALL implement the iterative shift-add multiplier (start, operands, product, done); top holds FSM and single-cycle datapath.

Verification (WIDTH=32)
REQ-028 ADD 0x7FFFFFFF+1 -> next cycle Out=0x80000000, Overflow=1, Zero=0, Done pulse.
REQ-029 SUB 5-5 -> Out=0, Zero=1, Overflow=0; SLT -1 vs 1 -> Out=1.
REQ-030 SRA 0x80000000 by Data_2=0x24 (amount 4) -> Out=0xF8000000; SLL 1 by 31 -> 0x80000000.
REQ-031 MUL 0x10000*0x10000 -> Busy 32 cycles, Out=0, Overflow=1, Done exactly at cycle 32; Start pulses and operand changes mid-op ignored.
REQ-032 MUL 1234*5678 then Start ADD in Done cycle -> Out=7006652, then ADD result next cycle, two Done pulses.
REQ-033 Reset asserted mid-MUL (cycle 10) -> outputs cleared asynchronously, no Done after release, next ADD 2+3 -> Out=5.

Source files
------------

// File: rtl/ula_pkg.sv
// ula_pkg: shared definitions for the multi-cycle ALU.
//   OP_*     : opcode encodings (OPC_W bits wide)
//   state_t  : controller FSM state encoding
package ula_pkg;

  localparam int OPC_W = 4;

  localparam logic [OPC_W-1:0] OP_ADD = 4'd0;
  localparam logic [OPC_W-1:0] OP_SUB = 4'd1;
  localparam logic [OPC_W-1:0] OP_AND = 4'd2;
  localparam logic [OPC_W-1:0] OP_OR  = 4'd3;
  localparam logic [OPC_W-1:0] OP_XOR = 4'd4;
  localparam logic [OPC_W-1:0] OP_NOR = 4'd5;
  localparam logic [OPC_W-1:0] OP_SLT = 4'd6;
  localparam logic [OPC_W-1:0] OP_SLL = 4'd7;
  localparam logic [OPC_W-1:0] OP_SRL = 4'd8;
  localparam logic [OPC_W-1:0] OP_SRA = 4'd9;
  localparam logic [OPC_W-1:0] OP_MUL = 4'd10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MULT = 1'b1
  } state_t;

endpackage

// File: rtl/ula_mult_iter.sv
// ula_mult_iter: iterative unsigned shift-add multiplier, one partial
// product per clock.
//   clk, rst   : clock, asynchronous active-high reset
//   i_start    : load operands and begin (ignored mid-operation by caller)
//   i_a, i_b   : multiplicand, multiplier
//   o_product  : full 2*WIDTH product, valid in the cycle o_done is high
//   o_done     : high during the last iteration; o_product is the result
//                that this iteration produces at the coming edge
module ula_mult_iter #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic [2*WIDTH-1:0] o_product,
  output logic               o_done
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [CNT_W-1:0] r_cnt;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_hi_nxt;
  logic [WIDTH-1:0] w_lo_nxt;

  // Multiplier bits are consumed from r_lo's LSB while the product's low
  // half shifts in from the top, so {hi,lo} ends up holding the product.
  assign w_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : '0);
  assign w_hi_nxt = w_sum[WIDTH:1];
  assign w_lo_nxt = {w_sum[0], r_lo[WIDTH-1:1]};

  assign o_product = {w_hi_nxt, w_lo_nxt};
  // Down-counter loaded with WIDTH; terminal count 1 marks the final step.
  assign o_done    = (r_cnt == CNT_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a   <= '0;
      r_hi  <= '0;
      r_lo  <= '0;
      r_cnt <= '0;
    end else if (i_start) begin
      r_a   <= i_a;
      r_hi  <= '0;
      r_lo  <= i_b;
      r_cnt <= CNT_W'(WIDTH);
    end else if (r_cnt != '0) begin
      r_hi  <= w_hi_nxt;
      r_lo  <= w_lo_nxt;
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/ula_multiciclo.sv
// ula_multiciclo: ALU with single-cycle logic/arith/shift ops and an
// iterative WIDTH-cycle multiply.
//   Clock_in, Signal_reset : clock, asynchronous active-high reset
//   Start, Sel             : request and opcode (sampled while Busy=0)
//   Data_1, Data_2         : operands
//   Out, Overflow, Zero    : registered result and flags
//   Busy                   : multiply in progress
//   Done                   : one-cycle pulse when Out/flags update
//
// state   | meaning
// IDLE    | accepting Start; single-cycle ops complete at the next edge
// MULT    | multiplier iterating; inputs ignored until it finishes
module ula_multiciclo
  import ula_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SEL_W = 4
) (
  input  logic             Clock_in,
  input  logic             Signal_reset,
  input  logic             Start,
  input  logic [SEL_W-1:0] Sel,
  input  logic [WIDTH-1:0] Data_1,
  input  logic [WIDTH-1:0] Data_2,
  output logic [WIDTH-1:0] Out,
  output logic             Overflow,
  output logic             Zero,
  output logic             Busy,
  output logic             Done
);

  localparam int SH_W = $clog2(WIDTH);

  state_t r_state, w_state_nxt;
  logic [WIDTH-1:0] r_out;
  logic             r_ovf, r_zero, r_done;

  logic [WIDTH-1:0]   w_sum, w_diff, w_res, w_load_res;
  logic [SH_W-1:0]    w_shamt;
  logic               w_ovf, w_load, w_load_ovf, w_mul_start, w_mul_done;
  logic [2*WIDTH-1:0] w_mul_prod;

  assign w_sum   = Data_1 + Data_2;
  assign w_diff  = Data_1 - Data_2;
  assign w_shamt = Data_2[SH_W-1:0];

  always_comb begin
    w_res = '0;
    w_ovf = 1'b0;
    case (Sel)
      SEL_W'(OP_ADD): begin
        w_res = w_sum;
        w_ovf = (Data_1[WIDTH-1] == Data_2[WIDTH-1]) && (w_sum[WIDTH-1] != Data_1[WIDTH-1]);
      end
      SEL_W'(OP_SUB): begin
        w_res = w_diff;
        w_ovf = (Data_1[WIDTH-1] != Data_2[WIDTH-1]) && (w_diff[WIDTH-1] != Data_1[WIDTH-1]);
      end
      SEL_W'(OP_AND): w_res = Data_1 & Data_2;
      SEL_W'(OP_OR):  w_res = Data_1 | Data_2;
      SEL_W'(OP_XOR): w_res = Data_1 ^ Data_2;
      SEL_W'(OP_NOR): w_res = ~(Data_1 | Data_2);
      SEL_W'(OP_SLT): w_res = {{(WIDTH-1){1'b0}}, ($signed(Data_1) < $signed(Data_2))};
      SEL_W'(OP_SLL): w_res = Data_1 << w_shamt;
      SEL_W'(OP_SRL): w_res = Data_1 >> w_shamt;
      SEL_W'(OP_SRA): w_res = $signed(Data_1) >>> w_shamt;
      default: ;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_load_res  = w_res;
    w_load_ovf  = w_ovf;
    w_mul_start = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (Start) begin
          if (Sel == SEL_W'(OP_MUL)) begin
            w_mul_start = 1'b1;
            w_state_nxt = ST_MULT;
          end else begin
            w_load = 1'b1;
          end
        end
      end
      ST_MULT: begin
        if (w_mul_done) begin
          w_load      = 1'b1;
          w_load_res  = w_mul_prod[WIDTH-1:0];
          w_load_ovf  = |w_mul_prod[2*WIDTH-1:WIDTH];
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock_in or posedge Signal_reset) begin
    if (Signal_reset) begin
      r_state <= ST_IDLE;
      r_out   <= '0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_load;
      if (w_load) begin
        r_out  <= w_load_res;
        r_ovf  <= w_load_ovf;
        r_zero <= (w_load_res == '0);
      end
    end
  end

  ula_mult_iter #(.WIDTH(WIDTH)) u_mult (
    .clk       (Clock_in),
    .rst       (Signal_reset),
    .i_start   (w_mul_start),
    .i_a       (Data_1),
    .i_b       (Data_2),
    .o_product (w_mul_prod),
    .o_done    (w_mul_done)
  );

  assign Out      = r_out;
  assign Overflow = r_ovf;
  assign Zero     = r_zero;
  assign Busy     = (r_state == ST_MULT);
  assign Done     = r_done;

endmodule

// File: tb/tb_ula_multiciclo.sv
// tb_ula_multiciclo: directed self-checking bench for ula_multiciclo
// (WIDTH=32). Expected results come from a 64-bit reference model and are
// queued when a request is driven, then popped when Done is seen.
module tb_ula_multiciclo;

  logic        Clock_in = 1'b0;
  logic        Signal_reset;
  logic        Start;
  logic [3:0]  Sel;
  logic [31:0] Data_1, Data_2;
  logic [31:0] Out;
  logic        Overflow, Zero, Busy, Done;

  typedef struct packed {
    logic [31:0] out;
    logic        ovf;
    logic        zr;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  ula_multiciclo #(.WIDTH(32), .SEL_W(4)) dut (
    .Clock_in     (Clock_in),
    .Signal_reset (Signal_reset),
    .Start        (Start),
    .Sel          (Sel),
    .Data_1       (Data_1),
    .Data_2       (Data_2),
    .Out          (Out),
    .Overflow     (Overflow),
    .Zero         (Zero),
    .Busy         (Busy),
    .Done         (Done)
  );

  always #5 Clock_in = ~Clock_in;

  function automatic exp_t model(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    longint      sa, sb, r;
    logic [31:0] lo;
    logic [63:0] p;
    logic [4:0]  sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = b[4:0];
    e  = '0;
    case (sel)
      4'd0: begin r = sa + sb; lo = r[31:0]; e.out = lo; e.ovf = (r != longint'($signed(lo))); end
      4'd1: begin r = sa - sb; lo = r[31:0]; e.out = lo; e.ovf = (r != longint'($signed(lo))); end
      4'd2: e.out = a & b;
      4'd3: e.out = a | b;
      4'd4: e.out = a ^ b;
      4'd5: e.out = ~(a | b);
      4'd6: e.out = (sa < sb) ? 32'd1 : 32'd0;
      4'd7: e.out = a << sh;
      4'd8: e.out = a >> sh;
      4'd9: begin r = sa >>> sh; e.out = r[31:0]; end
      4'd10: begin p = {32'd0, a} * {32'd0, b}; e.out = p[31:0]; e.ovf = |p[63:32]; end
      default: e = '0;
    endcase
    e.zr = (e.out == 32'd0);
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock_in);
    #1;
  endtask

  task automatic issue(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b);
    Start  = 1'b1;
    Sel    = s;
    Data_1 = a;
    Data_2 = b;
    q.push_back(model(s, a, b));
    tick();
    Start = 1'b0;
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    check({tag, "_sb"}, 64'(q.size() != 0), 64'(1));
    check({tag, "_done"}, 64'(Done), 64'(1));
    if (q.size() != 0) begin
      e = q.pop_front();
      check({tag, "_out"}, 64'(Out), 64'(e.out));
      check({tag, "_ovf"}, 64'(Overflow), 64'(e.ovf));
      check({tag, "_zero"}, 64'(Zero), 64'(e.zr));
    end
  endtask

  task automatic single(input string tag, input logic [3:0] s, input logic [31:0] a, input logic [31:0] b);
    issue(s, a, b);
    pop_check(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, nb, dn;
    Signal_reset = 1'b1;
    Start  = 1'b0;
    Sel    = '0;
    Data_1 = '0;
    Data_2 = '0;
    #12;
    check("rst_out",  64'(Out),      64'(0));
    check("rst_ovf",  64'(Overflow), 64'(0));
    check("rst_zero", 64'(Zero),     64'(1));
    check("rst_busy", 64'(Busy),     64'(0));
    check("rst_done", 64'(Done),     64'(0));

    // Start on the very first edge after release
    tick();
    Signal_reset = 1'b0;
    single("add_ovf", 4'd0, 32'h7FFF_FFFF, 32'h1);
    check("add_ovf_val", 64'(Out), 64'h8000_0000);

    tick();
    check("hold_done", 64'(Done),     64'(0));
    check("hold_out",  64'(Out),      64'h8000_0000);
    check("hold_ovf",  64'(Overflow), 64'(1));

    // back-to-back single-cycle ops
    single("sub_zero", 4'd1, 32'd5, 32'd5);
    single("slt_neg",  4'd6, 32'hFFFF_FFFF, 32'd1);
    check("slt_val", 64'(Out), 64'(1));
    single("sra", 4'd9, 32'h8000_0000, 32'h24);
    check("sra_val", 64'(Out), 64'hF800_0000);
    single("sll", 4'd7, 32'd1, 32'd31);
    check("sll_val", 64'(Out), 64'h8000_0000);
    single("and", 4'd2, 32'hF0F0_F0F0, 32'hFF00_FF00);
    single("or",  4'd3, 32'hF0F0_F0F0, 32'h0F00_0F01);
    single("xor", 4'd4, 32'hAAAA_5555, 32'hFFFF_0000);
    single("nor", 4'd5, 32'h0, 32'h0);
    single("srl", 4'd8, 32'h8000_0000, 32'h21);
    single("sub_ovf", 4'd1, 32'h8000_0000, 32'd1);
    single("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'd1);
    single("slt_pos", 4'd6, 32'd1, 32'hFFFF_FFFF);
    single("op11", 4'd11, 32'd3, 32'd4);
    single("op15", 4'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    // MUL with junk on the inputs while busy
    issue(4'd10, 32'h0001_0000, 32'h0001_0000);
    n = 0;
    nb = 0;
    while (!Done && n < 40) begin
      if (Busy) nb++;
      Start  = 1'($urandom_range(0, 1));
      Sel    = 4'($urandom);
      Data_1 = $urandom;
      Data_2 = $urandom;
      tick();
      n++;
    end
    Start = 1'b0;
    check("mul_latency", 64'(n), 64'(32));
    check("mul_busy_cycles", 64'(nb), 64'(32));
    check("mul_busy_end", 64'(Busy), 64'(0));
    pop_check("mul_big");
    tick();
    check("mul_single_done", 64'(Done), 64'(0));

    // MUL then ADD issued in the Done cycle
    issue(4'd10, 32'd1234, 32'd5678);
    n = 0;
    while (!Done && n < 40) begin
      tick();
      n++;
    end
    check("mul2_latency", 64'(n), 64'(32));
    pop_check("mul_1234");
    check("mul_1234_val", 64'(Out), 64'(7006652));
    issue(4'd0, 32'd100, 32'd23);
    pop_check("b2b_add");
    tick();
    check("b2b_done_low", 64'(Done), 64'(0));

    // reset in the middle of a multiply
    issue(4'd10, 32'd7, 32'd9);
    repeat (9) tick();
    check("mid_busy", 64'(Busy), 64'(1));
    Signal_reset = 1'b1;
    #2;
    check("arst_out",  64'(Out),      64'(0));
    check("arst_ovf",  64'(Overflow), 64'(0));
    check("arst_zero", 64'(Zero),     64'(1));
    check("arst_busy", 64'(Busy),     64'(0));
    check("arst_done", 64'(Done),     64'(0));
    q.delete();
    tick();
    tick();
    Signal_reset = 1'b0;
    dn = 0;
    repeat (40) begin
      tick();
      if (Done) dn++;
    end
    check("no_done_after_abort", 64'(dn), 64'(0));
    single("add_after_rst", 4'd0, 32'd2, 32'd3);
    check("add_after_rst_val", 64'(Out), 64'(5));

    check("sb_empty", 64'(q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
